// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing presets and shared helpers
package vga_pkg;

    typedef struct packed {
        int hdisp;
        int vdisp;
        int hfp;
        int hpulse;
        int hbp;
        int vfp;
        int vpulse;
        int vbp;
    } vga_timing_t;

    localparam vga_timing_t VGA_800x480 = '{
        hdisp: 800, vdisp: 480,
        hfp: 40, hpulse: 48, hbp: 40,
        vfp: 13, vpulse: 3, vbp: 29
    };

    localparam vga_timing_t VGA_640x480 = '{
        hdisp: 640, vdisp: 480,
        hfp: 16, hpulse: 96, hbp: 48,
        vfp: 10, vpulse: 2, vbp: 33
    };

    // Total period of one axis: blanking regions plus the visible region.
    function automatic int vga_total(input int disp, input int fp, input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

endpackage

// File: rtl/video_if.sv
// rtl/video_if.sv - video output bundle (clock, colour, syncs, visible flag)
interface video_if #(
    parameter int RGB_W = 24
) ();
    logic             CLK;
    logic [RGB_W-1:0] RGB;
    logic             HS;
    logic             VS;
    logic             BLANK;

    modport master (output CLK, output RGB, output HS, output VS, output BLANK);
    modport slave  (input CLK, input RGB, input HS, input VS, input BLANK);
endinterface

// File: rtl/vga_pipe_delay.sv
// rtl/vga_pipe_delay.sv - register delay line that resets to a constant
module vga_pipe_delay #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [DEPTH];

    // Shift the bundle one stage per cycle; reset fills every stage with RST_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator and latency-aligned pixel streamer
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int               HDISP     = VGA_800x480.hdisp,
    parameter int               VDISP     = VGA_800x480.vdisp,
    parameter int               HFP       = VGA_800x480.hfp,
    parameter int               HPULSE    = VGA_800x480.hpulse,
    parameter int               HBP       = VGA_800x480.hbp,
    parameter int               VFP       = VGA_800x480.vfp,
    parameter int               VPULSE    = VGA_800x480.vpulse,
    parameter int               VBP       = VGA_800x480.vbp,
    parameter bit               HS_POL    = 1'b0,
    parameter bit               VS_POL    = 1'b0,
    parameter int               LAT       = 1,
    parameter int               RGB_W     = 24,
    parameter logic [RGB_W-1:0] UFL_COLOR = RGB_W'(24'hFF00FF)
) (
    input  logic                      pixel_clk,
    input  logic                      pixel_rst,
    input  logic                      en,
    output logic                      pix_req,
    input  logic [RGB_W-1:0]          pix_data,
    input  logic                      pix_valid,
    video_if.master                   video_ifm,
    output logic [$clog2(HDISP)-1:0]  x,
    output logic [$clog2(VDISP)-1:0]  y,
    output logic                      frame_start,
    output logic                      underflow,
    output logic [15:0]               underflow_cnt
);
    localparam int HTOT = vga_total(HDISP, HFP, HPULSE, HBP);
    localparam int VTOT = vga_total(VDISP, VFP, VPULSE, VBP);
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);
    localparam int XW   = $clog2(HDISP);
    localparam int YW   = $clog2(VDISP);
    localparam int BW   = 3 + XW + YW;

    localparam logic [HW-1:0] H_LAST     = HW'(HTOT - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT      = HW'(HFP + HPULSE + HBP);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOT - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT      = VW'(VFP + VPULSE + VBP);

    logic          running;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic          act;
    logic          hs_raw;
    logic          vs_raw;
    logic [XW-1:0] x_raw;
    logic [YW-1:0] y_raw;

    logic [BW-1:0] dec_bundle;
    logic [BW-1:0] dly_bundle;
    logic          act_d;
    logic          hs_d;
    logic          vs_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;

    logic [RGB_W-1:0] rgb_q;
    logic             hs_q;
    logic             vs_q;
    logic             blank_q;

    // Start latch: the first en=1 starts the raster, later en values are ignored.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            running <= 1'b0;
        end else if (en) begin
            running <= 1'b1;
        end
    end

    // Raster counters; they sit at zero until the start latch is set.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (running) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Decode position into visible/sync flags and pixel coordinates (blanking first).
    always_comb begin
        act    = running && (h_cnt >= H_ACT) && (v_cnt >= V_ACT);
        hs_raw = running && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        vs_raw = running && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        x_raw  = act ? XW'(h_cnt - H_ACT) : '0;
        y_raw  = act ? YW'(v_cnt - V_ACT) : '0;
    end

    assign pix_req    = act;
    assign dec_bundle = {act, hs_raw, vs_raw, x_raw, y_raw};

    // Timing fields travel LAT cycles so they meet the pixel fetched for them.
    vga_pipe_delay #(
        .W       (BW),
        .DEPTH   (LAT),
        .RST_VAL ('0)
    ) u_delay (
        .clk (pixel_clk),
        .rst (pixel_rst),
        .d   (dec_bundle),
        .q   (dly_bundle)
    );

    assign {act_d, hs_d, vs_d, x_d, y_d} = dly_bundle;

    // Output register: syncs, visible flag, coordinates and colour leave together.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            blank_q     <= 1'b0;
            rgb_q       <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            hs_q        <= hs_d ? HS_POL : ~HS_POL;
            vs_q        <= vs_d ? VS_POL : ~VS_POL;
            blank_q     <= act_d;
            rgb_q       <= act_d ? (pix_valid ? pix_data : UFL_COLOR) : '0;
            x           <= x_d;
            y           <= y_d;
            frame_start <= act_d && (x_d == '0) && (y_d == '0);
        end
    end

    // Missing upstream pixel in its expected cycle: flag stickily and count, saturating.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else if (act_d && !pix_valid) begin
            underflow <= 1'b1;
            if (underflow_cnt != 16'hFFFF) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

    assign video_ifm.CLK   = pixel_clk;
    assign video_ifm.RGB   = rgb_q;
    assign video_ifm.HS    = hs_q;
    assign video_ifm.VS    = vs_q;
    assign video_ifm.BLANK = blank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    logic en;

    int compared;
    int mismatched;

    // Small timing, LAT=1
    logic        req1, fs1, uf1, pv1;
    logic [1:0]  x1;
    logic [0:0]  y1;
    logic [15:0] ucnt1;
    logic [23:0] pd1;
    video_if #(.RGB_W(24)) vif1 ();

    // Small timing, LAT=3
    logic        req3, fs3, uf3, pv3;
    logic [1:0]  x3;
    logic [0:0]  y3;
    logic [15:0] ucnt3;
    logic [23:0] pd3;
    video_if #(.RGB_W(24)) vif3 ();

    // Small timing, active-high syncs
    logic        reqp, fsp, ufp, pvp;
    logic [1:0]  xp;
    logic [0:0]  yp;
    logic [15:0] ucntp;
    logic [23:0] pdp;
    video_if #(.RGB_W(24)) vifp ();

    // Large timing for counter saturation (HTOT=256, VTOT=512)
    logic        reqb, fsb, ufb, pvb;
    logic [7:0]  xb;
    logic [8:0]  yb;
    logic [15:0] ucntb;
    logic [23:0] pdb;
    video_if #(.RGB_W(24)) vifb ();

    vga_timing_gen #(
        .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(1), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LAT(1), .RGB_W(24), .UFL_COLOR(24'hFF00FF)
    ) u1 (
        .pixel_clk(clk), .pixel_rst(rst), .en(en), .pix_req(req1), .pix_data(pd1),
        .pix_valid(pv1), .video_ifm(vif1), .x(x1), .y(y1), .frame_start(fs1),
        .underflow(uf1), .underflow_cnt(ucnt1)
    );

    vga_timing_gen #(
        .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(1), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LAT(3), .RGB_W(24), .UFL_COLOR(24'hFF00FF)
    ) u3 (
        .pixel_clk(clk), .pixel_rst(rst), .en(en), .pix_req(req3), .pix_data(pd3),
        .pix_valid(pv3), .video_ifm(vif3), .x(x3), .y(y3), .frame_start(fs3),
        .underflow(uf3), .underflow_cnt(ucnt3)
    );

    vga_timing_gen #(
        .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(1), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .LAT(1), .RGB_W(24), .UFL_COLOR(24'hFF00FF)
    ) up (
        .pixel_clk(clk), .pixel_rst(rst), .en(en), .pix_req(reqp), .pix_data(pdp),
        .pix_valid(pvp), .video_ifm(vifp), .x(xp), .y(yp), .frame_start(fsp),
        .underflow(ufp), .underflow_cnt(ucntp)
    );

    vga_timing_gen #(
        .HDISP(253), .VDISP(509), .HFP(1), .HPULSE(1), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LAT(1), .RGB_W(24), .UFL_COLOR(24'hFF00FF)
    ) ub (
        .pixel_clk(clk), .pixel_rst(rst), .en(en), .pix_req(reqb), .pix_data(pdb),
        .pix_valid(pvb), .video_ifm(vifb), .x(xb), .y(yb), .frame_start(fsb),
        .underflow(ufb), .underflow_cnt(ucntb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not reach summary in time");
        $fatal(1, "watchdog expired");
    end

    // Small timing, cycle k after start: h=k%7, v=(k/7)%5
    function automatic bit req_at(input int k);
        if (k < 0) return 1'b0;
        return ((k % 7) >= 3) && (((k / 7) % 5) >= 3);
    endfunction

    function automatic bit hs_at(input int k);
        if (k < 0) return 1'b0;
        return (k % 7) == 1;
    endfunction

    function automatic bit vs_at(input int k);
        if (k < 0) return 1'b0;
        return ((k / 7) % 5) == 1;
    endfunction

    // Pulse reset, then a one-cycle en; returns at the falling edge of cycle 0.
    task automatic start_run();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (50) begin
            @(negedge clk);
            compared++; if (vif1.HS !== 1'b1) begin mismatched++; $display("FAIL rst_hs got=%b exp=1", vif1.HS); end
            compared++; if (vif1.VS !== 1'b1) begin mismatched++; $display("FAIL rst_vs got=%b exp=1", vif1.VS); end
            compared++; if (vif1.BLANK !== 1'b0) begin mismatched++; $display("FAIL rst_blank got=%b exp=0", vif1.BLANK); end
            compared++; if (vif1.RGB !== 24'h0) begin mismatched++; $display("FAIL rst_rgb got=%h exp=0", vif1.RGB); end
            compared++; if (req1 !== 1'b0) begin mismatched++; $display("FAIL rst_req got=%b exp=0", req1); end
            compared++; if (fs1 !== 1'b0 || uf1 !== 1'b0 || ucnt1 !== 16'h0 || x1 !== 2'd0 || y1 !== 1'd0) begin
                mismatched++; $display("FAIL rst_misc fs=%b uf=%b cnt=%h x=%0d y=%0d exp all 0", fs1, uf1, ucnt1, x1, y1);
            end
            compared++; if (vifp.HS !== 1'b0 || vifp.VS !== 1'b0) begin
                mismatched++; $display("FAIL rst_pol hs=%b vs=%b exp=0/0", vifp.HS, vifp.VS);
            end
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            compared++; if (req1 !== 1'b0 || vif1.BLANK !== 1'b0 || vif1.HS !== 1'b1 || vif1.RGB !== 24'h0) begin
                mismatched++; $display("FAIL idle req=%b blank=%b hs=%b rgb=%h exp 0/0/1/0", req1, vif1.BLANK, vif1.HS, vif1.RGB);
            end
        end
    endtask

    task automatic test_stream();
        int      per_frame [3];
        int      runs;
        int      fs_seen;
        bit      prev;
        bit      vis;
        logic [23:0] rgb_e;
        logic [1:0]  x_e;
        logic [0:0]  y_e;
        per_frame = '{0, 0, 0};
        runs = 0; fs_seen = 0; prev = 1'b0;
        pv1 = 1'b1; pv3 = 1'b1;
        start_run();
        for (int k = 0; k < 105; k++) begin
            pd1 = 24'(k - 1);
            pd3 = 24'(k - 3);
            vis   = req_at(k - 2);
            rgb_e = vis ? 24'(k - 2) : 24'h0;
            compared++; if (req1 !== req_at(k)) begin mismatched++; $display("FAIL req k=%0d got=%b exp=%b", k, req1, req_at(k)); end
            compared++; if (vif1.BLANK !== vis) begin mismatched++; $display("FAIL blank k=%0d got=%b exp=%b", k, vif1.BLANK, vis); end
            compared++; if (vif1.HS !== !hs_at(k - 2)) begin mismatched++; $display("FAIL hs k=%0d got=%b exp=%b", k, vif1.HS, !hs_at(k - 2)); end
            compared++; if (vif1.VS !== !vs_at(k - 2)) begin mismatched++; $display("FAIL vs k=%0d got=%b exp=%b", k, vif1.VS, !vs_at(k - 2)); end
            compared++; if (vif1.RGB !== rgb_e) begin mismatched++; $display("FAIL rgb k=%0d got=%h exp=%h", k, vif1.RGB, rgb_e); end
            compared++; if (fs1 !== (k >= 2 && ((k - 2) % 35) == 24)) begin
                mismatched++; $display("FAIL frame_start k=%0d got=%b", k, fs1);
            end
            if (vis) begin
                x_e = 2'(((k - 2) % 7) - 3);
                y_e = 1'((((k - 2) / 7) % 5) - 3);
                compared++; if (x1 !== x_e || y1 !== y_e) begin
                    mismatched++; $display("FAIL xy k=%0d got=%0d,%0d exp=%0d,%0d", k, x1, y1, x_e, y_e);
                end
            end
            per_frame[k / 35] += int'(req1);
            if (req1 && !prev) runs++;
            prev = req1;
            fs_seen += int'(fs1);
            @(negedge clk);
        end
        for (int f = 0; f < 3; f++) begin
            compared++; if (per_frame[f] != 8) begin mismatched++; $display("FAIL req_per_frame f=%0d got=%0d exp=8", f, per_frame[f]); end
        end
        compared++; if (runs != 6) begin mismatched++; $display("FAIL req_runs got=%0d exp=6", runs); end
        compared++; if (fs_seen != 3) begin mismatched++; $display("FAIL frame_start_count got=%0d exp=3", fs_seen); end
        compared++; if (uf1 !== 1'b0 || ucnt1 !== 16'h0) begin mismatched++; $display("FAIL no_underflow uf=%b cnt=%h exp 0/0", uf1, ucnt1); end
    endtask

    task automatic test_latency();
        bit vis;
        logic [23:0] rgb_e;
        pv1 = 1'b1; pv3 = 1'b1;
        start_run();
        for (int k = 0; k < 80; k++) begin
            pd1 = 24'(k - 1);
            pd3 = 24'(k - 3);
            vis   = req_at(k - 4);
            rgb_e = vis ? 24'(k - 4) : 24'h0;
            compared++; if (req3 !== req_at(k)) begin mismatched++; $display("FAIL lat3_req k=%0d got=%b exp=%b", k, req3, req_at(k)); end
            compared++; if (vif3.BLANK !== vis) begin mismatched++; $display("FAIL lat3_blank k=%0d got=%b exp=%b", k, vif3.BLANK, vis); end
            compared++; if (vif3.HS !== !hs_at(k - 4)) begin mismatched++; $display("FAIL lat3_hs k=%0d got=%b", k, vif3.HS); end
            compared++; if (vif3.VS !== !vs_at(k - 4)) begin mismatched++; $display("FAIL lat3_vs k=%0d got=%b", k, vif3.VS); end
            compared++; if (vif3.RGB !== rgb_e) begin mismatched++; $display("FAIL lat3_rgb k=%0d got=%h exp=%h", k, vif3.RGB, rgb_e); end
            compared++; if (fs3 !== (k >= 4 && ((k - 4) % 35) == 24)) begin
                mismatched++; $display("FAIL lat3_frame_start k=%0d got=%b", k, fs3);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_underflow();
        bit vis;
        logic [23:0] rgb_e;
        logic [15:0] cnt_e;
        pv1 = 1'b1;
        start_run();
        for (int k = 0; k < 70; k++) begin
            pd1 = 24'(k - 1);
            pv1 = !((k <= 10) || (k >= 25 && k <= 27));
            vis = req_at(k - 2);
            if (!vis) rgb_e = 24'h0;
            else if (k >= 26 && k <= 28) rgb_e = 24'hFF00FF;
            else rgb_e = 24'(k - 2);
            cnt_e = (k <= 25) ? 16'd0 : (k == 26) ? 16'd1 : (k == 27) ? 16'd2 : 16'd3;
            compared++; if (vif1.RGB !== rgb_e) begin mismatched++; $display("FAIL ufl_rgb k=%0d got=%h exp=%h", k, vif1.RGB, rgb_e); end
            compared++; if (uf1 !== (k >= 26)) begin mismatched++; $display("FAIL ufl_flag k=%0d got=%b", k, uf1); end
            compared++; if (ucnt1 !== cnt_e) begin mismatched++; $display("FAIL ufl_cnt k=%0d got=%0d exp=%0d", k, ucnt1, cnt_e); end
            @(negedge clk);
        end
        pv1 = 1'b1;
    endtask

    task automatic test_polarity();
        int hs_hi;
        int vs_hi;
        hs_hi = 0; vs_hi = 0;
        pvp = 1'b1; pdp = 24'h0;
        start_run();
        for (int k = 0; k < 72; k++) begin
            compared++; if (vifp.HS !== hs_at(k - 2)) begin mismatched++; $display("FAIL pol_hs k=%0d got=%b exp=%b", k, vifp.HS, hs_at(k - 2)); end
            compared++; if (vifp.VS !== vs_at(k - 2)) begin mismatched++; $display("FAIL pol_vs k=%0d got=%b exp=%b", k, vifp.VS, vs_at(k - 2)); end
            if (k >= 2) begin
                hs_hi += int'(vifp.HS);
                vs_hi += int'(vifp.VS);
            end
            @(negedge clk);
        end
        compared++; if (hs_hi != 10) begin mismatched++; $display("FAIL pol_hs_count got=%0d exp=10", hs_hi); end
        compared++; if (vs_hi != 14) begin mismatched++; $display("FAIL pol_vs_count got=%0d exp=14", vs_hi); end
    endtask

    task automatic test_reset_midframe();
        int first_req;
        pv1 = 1'b0;
        start_run();
        for (int k = 0; k < 55; k++) begin
            pd1 = 24'(k - 1);
            @(negedge clk);
        end
        compared++; if (uf1 !== 1'b1 || ucnt1 !== 16'd8) begin
            mismatched++; $display("FAIL pre_reset uf=%b cnt=%0d exp 1/8", uf1, ucnt1);
        end
        #1 rst = 1'b1;
        #1;
        compared++; if (vif1.HS !== 1'b1 || vif1.VS !== 1'b1 || vif1.BLANK !== 1'b0 || vif1.RGB !== 24'h0) begin
            mismatched++; $display("FAIL async_rst_video hs=%b vs=%b blank=%b rgb=%h", vif1.HS, vif1.VS, vif1.BLANK, vif1.RGB);
        end
        compared++; if (req1 !== 1'b0 || fs1 !== 1'b0 || uf1 !== 1'b0 || ucnt1 !== 16'h0 || x1 !== 2'd0 || y1 !== 1'd0) begin
            mismatched++; $display("FAIL async_rst_misc req=%b fs=%b uf=%b cnt=%h x=%0d y=%0d", req1, fs1, uf1, ucnt1, x1, y1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pv1 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            compared++; if (req1 !== 1'b0 || vif1.BLANK !== 1'b0) begin
                mismatched++; $display("FAIL post_rst_idle req=%b blank=%b exp 0/0", req1, vif1.BLANK);
            end
        end
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        first_req = -1;
        for (int k = 0; k < 31; k++) begin
            pd1 = 24'(k - 1);
            if (req1 && first_req < 0) first_req = k;
            @(negedge clk);
        end
        compared++; if (first_req != 24) begin mismatched++; $display("FAIL restart_first_req got=%0d exp=24", first_req); end
    endtask

    task automatic test_saturation();
        pvb = 1'b0; pdb = 24'h0;
        start_run();
        for (int k = 0; k <= 67200; k++) begin
            if (k == 1024) begin
                compared++; if (ucntb !== 16'd252) begin mismatched++; $display("FAIL sat_cnt_1024 got=%0d exp=252", ucntb); end
            end
            if (k == 1026) begin
                compared++; if (ucntb !== 16'd253) begin mismatched++; $display("FAIL sat_cnt_1026 got=%0d exp=253", ucntb); end
            end
            if (k == 67200) begin
                compared++; if (ucntb !== 16'hFFFF) begin mismatched++; $display("FAIL sat_cnt got=%h exp=ffff", ucntb); end
                compared++; if (ufb !== 1'b1) begin mismatched++; $display("FAIL sat_flag got=%b exp=1", ufb); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1; en = 1'b0;
        pd1 = '0; pd3 = '0; pdp = '0; pdb = '0;
        pv1 = 1'b1; pv3 = 1'b1; pvp = 1'b1; pvb = 1'b0;
        test_reset();
        test_stream();
        test_latency();
        test_underflow();
        test_polarity();
        test_reset_midframe();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
